// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared definitions for the fetch/memory-port sequencer and the
//   instruction-hold stage: inst_sel encodings, FSM state encodings,
//   memory-owner constants and the per-state output decode.
package fetch_ctrl_pkg;

  // inst_sel encodings; must match the instruction-hold stage mux
  localparam logic [1:0] INST_OLD = 2'b00;
  localparam logic [1:0] INST_NOP = 2'b01;
  localparam logic [1:0] INST_MEM = 2'b10;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DATA   = 3'd3,
    ST_REFILL = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic [1:0] inst_sel;
    logic       pc_en;
    logic       mem_owner;
    logic       data_gnt;
  } outs_t;

  // Moore output table: every sequencing output is a pure function of state
  function automatic outs_t state_outs(input state_e s);
    outs_t o;
    case (s)
      ST_RUN:    o = '{INST_MEM, 1'b1, OWN_FETCH, 1'b0};
      ST_FLUSH:  o = '{INST_NOP, 1'b1, OWN_FETCH, 1'b0};
      ST_DATA:   o = '{INST_OLD, 1'b0, OWN_DATA,  1'b1};
      ST_REFILL: o = '{INST_OLD, 1'b0, OWN_FETCH, 1'b0};
      ST_HALT:   o = '{INST_OLD, 1'b0, OWN_FETCH, 1'b0};
      default:   o = '{INST_NOP, 1'b1, OWN_FETCH, 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter
//   Width-parameterised incrementer that sticks at all-ones instead of
//   wrapping. Synchronous clear.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears count)
//   i_clr  synchronous clear
//   i_inc  increment enable
//   o_cnt  current count
module sat_counter
  import fetch_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Sequencer for the instruction-hold/NOP-insertion stage and the single
//   shared synchronous memory port. Arbitrates fetch vs. load/store,
//   inserts NOP bubbles at boot and after taken branches, and counts
//   cycles with the PC frozen.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_branch_taken    execute resolved a taken branch/jump
//   i_data_req        load/store needs the memory port
//   i_halt            level-sensitive freeze request
//   o_inst_sel        instruction-hold select (OLD/NOP/MEM)
//   o_pc_en           PC update enable
//   o_mem_owner       0 = fetch owns address, 1 = data side
//   o_data_gnt        data access granted this cycle
//   o_busy            high in every state except RUN
//   o_stall_cnt       saturating count of cycles with pc_en=0
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN = 2,
  parameter int DATA_LEN  = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_branch_taken,
  input  logic             i_data_req,
  input  logic             i_halt,
  output logic [1:0]       o_inst_sel,
  output logic             o_pc_en,
  output logic             o_mem_owner,
  output logic             o_data_gnt,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_LEN - 1);
  localparam logic [2:0] DATA_LOAD  = 3'(DATA_LEN - 1);

  state_e     r_state;
  logic [2:0] r_flush_cnt;
  logic [2:0] r_data_cnt;
  logic       r_pend_branch;
  logic       r_pend_halt;
  logic       r_pend_data;

  // a request seen this cycle counts the same as one already pending
  logic  w_branch_any;
  logic  w_halt_any;
  logic  w_data_any;
  outs_t w_outs;

  assign w_branch_any = r_pend_branch | i_branch_taken;
  assign w_halt_any   = r_pend_halt | i_halt;
  assign w_data_any   = r_pend_data | i_data_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_flush_cnt   <= '0;
      r_data_cnt    <= '0;
      r_pend_branch <= 1'b0;
      r_pend_halt   <= 1'b0;
      r_pend_data   <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;

        ST_RUN: begin
          if (i_branch_taken) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
            r_pend_halt <= w_halt_any;
            r_pend_data <= w_data_any;
          end else if (w_halt_any) begin
            r_state     <= ST_HALT;
            r_pend_halt <= 1'b0;
            r_pend_data <= w_data_any;
          end else if (w_data_any) begin
            r_state     <= ST_DATA;
            r_data_cnt  <= DATA_LOAD;
            r_pend_data <= 1'b0;
          end
        end

        ST_FLUSH: begin
          r_pend_halt <= w_halt_any;
          r_pend_data <= w_data_any;
          if (i_branch_taken) begin
            r_flush_cnt <= FLUSH_LOAD;
          end else if (r_flush_cnt != 3'd0) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end else if (w_halt_any) begin
            r_state     <= ST_HALT;
            r_pend_halt <= 1'b0;
          end else if (w_data_any) begin
            r_state     <= ST_DATA;
            r_data_cnt  <= DATA_LOAD;
            r_pend_data <= 1'b0;
          end else begin
            r_state <= ST_RUN;
          end
        end

        // the access always completes; branch/halt only get recorded
        ST_DATA: begin
          r_pend_branch <= w_branch_any;
          r_pend_halt   <= w_halt_any;
          if (r_data_cnt != 3'd0) begin
            r_data_cnt <= r_data_cnt - 3'd1;
          end else if (w_branch_any) begin
            // rdata is a data word, so the refetch happens at the target instead
            r_state       <= ST_FLUSH;
            r_flush_cnt   <= FLUSH_LOAD;
            r_pend_branch <= 1'b0;
          end else if (w_halt_any) begin
            r_state     <= ST_HALT;
            r_pend_halt <= 1'b0;
          end else begin
            r_state <= ST_REFILL;
          end
        end

        ST_REFILL: begin
          r_pend_halt <= w_halt_any;
          r_pend_data <= w_data_any;
          if (i_branch_taken) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
          end else begin
            r_state <= ST_RUN;
          end
        end

        // execute is frozen here, so branch_taken is not meaningful
        ST_HALT: begin
          r_pend_data <= w_data_any;
          if (!i_halt) r_state <= ST_REFILL;
        end

        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign w_outs      = state_outs(r_state);
  assign o_inst_sel  = w_outs.inst_sel;
  assign o_pc_en     = w_outs.pc_en;
  assign o_mem_owner = w_outs.mem_owner;
  assign o_data_gnt  = w_outs.data_gnt;
  assign o_busy      = (r_state != ST_RUN);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_inc (~w_outs.pc_en),
    .o_cnt (o_stall_cnt)
  );

endmodule
